// File: rtl/spi_sub_ctrl.sv
// SPI slave-side control: synchronizes the pad sclk/ss, detects mode-dependent sample and
// shift edges, and sequences load/shift strobes for external shift registers and the TX/RX FIFOs.
`timescale 1ns/1ps
module spi_sub_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       sclk_pad_i,
   input  logic       ss_pad_i,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       tx_fifo_empty,
   input  logic       rx_fifo_full,
   input  logic       clr_status,
   output logic       load_from_fifo,
   output logic       slave_transfer_shift_en,
   output logic       slave_receive_shift_en,
   output logic       tx_fifo_rd,
   output logic       rx_fifo_wr,
   output logic       busy,
   output logic       tx_underflow,
   output logic       rx_overflow,
   output logic [1:0] state_dbg
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, XFER = 2'd2} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync;
   logic                   sclk_d, ss_d;
   logic [SYNC_STAGES:0]   flush_sr;
   logic                   armed;
   logic                   sclk_s, ss_s, lead, trail, sample_edge, shift_edge, ss_fall;

   logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
   logic             byte_done, byte_done_nxt;
   logic             fresh, fresh_nxt;
   logic             rx_pending, rx_pending_nxt;

   // sclk is normalized by cpol before the synchronizer, so its idle level is always 0
   // and the leading edge is always a rising edge of the normalized signal.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b1;
         flush_sr  <= '0;
         armed     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pad_i ^ cpol};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_pad_i};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         ss_d      <= ss_sync[SYNC_STAGES-1];
         flush_sr  <= {flush_sr[SYNC_STAGES-1:0], 1'b1};
         armed     <= armed | (flush_sr[SYNC_STAGES] & ss_s);
      end
   end

   assign sclk_s      = sclk_sync[SYNC_STAGES-1];
   assign ss_s        = ss_sync[SYNC_STAGES-1];
   assign lead        = sclk_s & ~sclk_d;
   assign trail       = ~sclk_s & sclk_d;
   assign sample_edge = cpha ? trail : lead;
   assign shift_edge  = cpha ? lead : trail;
   // The reset value of the ss chain is not a real pad level; only a fall seen after
   // ss was observed high post-reset may start a frame.
   assign ss_fall     = armed & ss_d & ~ss_s;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         byte_done    <= 1'b0;
         fresh        <= 1'b0;
         rx_pending   <= 1'b0;
         tx_underflow <= 1'b0;
         rx_overflow  <= 1'b0;
      end else begin
         state        <= state_nxt;
         bit_cnt      <= bit_cnt_nxt;
         byte_done    <= byte_done_nxt;
         fresh        <= fresh_nxt;
         rx_pending   <= rx_pending_nxt;
         tx_underflow <= (load_from_fifo & tx_fifo_empty) | (tx_underflow & ~clr_status);
         rx_overflow  <= (rx_pending & rx_fifo_full) | (rx_overflow & ~clr_status);
      end
   end

   always_comb begin
      state_nxt               = state;
      bit_cnt_nxt             = bit_cnt;
      byte_done_nxt           = byte_done;
      fresh_nxt               = fresh;
      rx_pending_nxt          = 1'b0;
      load_from_fifo          = 1'b0;
      slave_transfer_shift_en = 1'b0;
      slave_receive_shift_en  = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) state_nxt = LOAD;
         end
         LOAD: begin
            load_from_fifo = 1'b1;
            bit_cnt_nxt    = '0;
            byte_done_nxt  = 1'b0;
            fresh_nxt      = 1'b1;
            state_nxt      = XFER;
         end
         XFER: begin
            // ss high has priority, so an sclk edge arriving in that cycle is dropped.
            if (ss_s) begin
               state_nxt     = IDLE;
               bit_cnt_nxt   = '0;
               byte_done_nxt = 1'b0;
               fresh_nxt     = 1'b0;
            end else if (sample_edge) begin
               slave_receive_shift_en = 1'b1;
               if (!cpha) fresh_nxt = 1'b0;
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt_nxt    = '0;
                  byte_done_nxt  = 1'b1;
                  rx_pending_nxt = 1'b1;
               end else begin
                  bit_cnt_nxt = bit_cnt + CNT_W'(1);
               end
            end else if (shift_edge) begin
               if (byte_done) begin
                  load_from_fifo = 1'b1;
                  byte_done_nxt  = 1'b0;
               end else if (fresh && cpha) begin
                  fresh_nxt = 1'b0;
               end else begin
                  slave_transfer_shift_en = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign tx_fifo_rd = load_from_fifo & ~tx_fifo_empty;
   assign rx_fifo_wr = rx_pending & ~rx_fifo_full;
   assign busy       = (state != IDLE);
   assign state_dbg  = state;

endmodule

// File: tb/tb_spi_sub_ctrl.sv
// Directed bench for spi_sub_ctrl: drives SPI frames on the pads, models the external
// TX/RX shift registers from the strobes, and checks counts, data and flags.
`timescale 1ns/1ps
module tb_spi_sub_ctrl;

   localparam int HALF = 80;

   logic       pclk = 1'b0, rst = 1'b1;
   logic       sclk_pad_i = 1'b0, ss_pad_i = 1'b1, cpol = 1'b0, cpha = 1'b0;
   logic       tx_fifo_empty = 1'b0, rx_fifo_full = 1'b0, clr_status = 1'b0;
   logic       load_from_fifo, slave_transfer_shift_en, slave_receive_shift_en;
   logic       tx_fifo_rd, rx_fifo_wr, busy, tx_underflow, rx_overflow;
   logic [1:0] state_dbg;

   logic        mosi = 1'b0;
   logic [7:0]  tx_word = 8'h00, tx_sr = 8'h00, rx_sr = 8'h00;
   logic [15:0] somi_bits = 16'h0000;
   logic [7:0]  exp_q[$];
   int loads, rds, shifts, recvs, wrs, overlaps, lead_cnt, lead_at_load;
   int n_checks = 0, n_pass = 0, n_fail = 0;

   spi_sub_ctrl #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .pclk(pclk), .rst(rst), .sclk_pad_i(sclk_pad_i), .ss_pad_i(ss_pad_i),
      .cpol(cpol), .cpha(cpha), .tx_fifo_empty(tx_fifo_empty), .rx_fifo_full(rx_fifo_full),
      .clr_status(clr_status), .load_from_fifo(load_from_fifo),
      .slave_transfer_shift_en(slave_transfer_shift_en),
      .slave_receive_shift_en(slave_receive_shift_en), .tx_fifo_rd(tx_fifo_rd),
      .rx_fifo_wr(rx_fifo_wr), .busy(busy), .tx_underflow(tx_underflow),
      .rx_overflow(rx_overflow), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // shift register model and scoreboard
   always @(negedge pclk) begin
      logic [7:0] e;
      if (load_from_fifo && slave_transfer_shift_en) overlaps++;
      if (slave_receive_shift_en && (load_from_fifo || slave_transfer_shift_en)) overlaps++;
      if (rx_fifo_wr) begin
         wrs++;
         if (exp_q.size() != 0) e = exp_q.pop_front();
         else e = 'x;
         chk("rx_byte", {24'd0, rx_sr}, {24'd0, e});
      end
      if (slave_receive_shift_en) begin
         recvs++;
         somi_bits = {somi_bits[14:0], tx_sr[7]};
         rx_sr     = {rx_sr[6:0], mosi};
      end
      if (slave_transfer_shift_en) begin
         shifts++;
         tx_sr = {tx_sr[6:0], 1'b0};
      end
      if (load_from_fifo) begin
         loads++;
         lead_at_load = lead_cnt;
         tx_sr = tx_word;
      end
      if (tx_fifo_rd) rds++;
   end

   // driver tasks
   task automatic reset_counts();
      loads = 0; rds = 0; shifts = 0; recvs = 0; wrs = 0; overlaps = 0;
      lead_cnt = 0; lead_at_load = -1; somi_bits = 16'h0000;
   endtask

   task automatic set_mode(input logic p, input logic h);
      cpol = p; cpha = h; sclk_pad_i = p;
      repeat (6) @(negedge pclk);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, input bit ss_with_last);
      for (int i = 0; i < n; i++) begin
         if (!cpha) begin
            mosi = b[7-i];
            #HALF; sclk_pad_i = ~cpol; lead_cnt++;
            #HALF; sclk_pad_i = cpol;
            if (ss_with_last && i == n - 1) ss_pad_i = 1'b1;
         end else begin
            sclk_pad_i = ~cpol; lead_cnt++; mosi = b[7-i];
            #HALF; sclk_pad_i = cpol;
            #HALF;
         end
      end
   endtask

   task automatic frame_start();
      ss_pad_i = 1'b0;
      #(2*HALF);
   endtask

   task automatic frame_end();
      #HALF; ss_pad_i = 1'b1;
      #(2*HALF);
   endtask

   task automatic pulse_clr();
      @(negedge pclk); clr_status = 1'b1;
      @(negedge pclk); clr_status = 1'b0;
      @(negedge pclk);
   endtask

   initial begin
      int n;
      reset_counts();
      repeat (3) @(negedge pclk);
      chk("rst_state", state_dbg, 0);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {load_from_fifo, slave_transfer_shift_en, slave_receive_shift_en,
                          tx_fifo_rd, rx_fifo_wr}, 0);
      chk("rst_flags", {tx_underflow, rx_overflow}, 0);
      rst = 1'b0;
      repeat (6) @(negedge pclk);

      // mode 0, single byte; ss rises with the final falling edge so no reload follows
      set_mode(1'b0, 1'b0);
      reset_counts(); tx_word = 8'h5A; exp_q.push_back(8'hA5);
      frame_start();
      chk("m0_state_xfer", state_dbg, 2);
      chk("m0_busy", busy, 1);
      send_bits(8'hA5, 8, 1'b1);
      #(2*HALF);
      chk("m0_loads", loads, 1);
      chk("m0_rds", rds, 1);
      chk("m0_shifts", shifts, 7);
      chk("m0_recvs", recvs, 8);
      chk("m0_wrs", wrs, 1);
      chk("m0_somi", somi_bits[7:0], 8'h5A);
      chk("m0_overlap", overlaps, 0);
      chk("m0_idle", state_dbg, 0);

      // mode 3, two back-to-back bytes
      set_mode(1'b1, 1'b1);
      reset_counts(); tx_word = 8'h96;
      exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
      frame_start();
      send_bits(8'h3C, 8, 1'b0);
      send_bits(8'hC3, 8, 1'b0);
      frame_end();
      chk("m3_loads", loads, 2);
      chk("m3_rds", rds, 2);
      chk("m3_second_load_edge", lead_at_load, 9);
      chk("m3_wrs", wrs, 2);
      chk("m3_shifts", shifts, 14);
      chk("m3_recvs", recvs, 16);
      chk("m3_somi", somi_bits, 16'h9696);
      chk("m3_overlap", overlaps, 0);
      chk("m3_q_empty", exp_q.size(), 0);

      // mode 1, TX FIFO empty at the frame load
      set_mode(1'b0, 1'b1);
      reset_counts(); tx_fifo_empty = 1'b1; exp_q.push_back(8'h5C);
      frame_start();
      chk("uf_loads", loads, 1);
      chk("uf_rds", rds, 0);
      chk("uf_flag", tx_underflow, 1);
      tx_fifo_empty = 1'b0;
      send_bits(8'h5C, 8, 1'b0);
      frame_end();
      chk("uf_wrs", wrs, 1);
      chk("uf_sticky", tx_underflow, 1);
      chk("uf_loads_end", loads, 1);
      pulse_clr();
      chk("uf_cleared", tx_underflow, 0);

      // RX FIFO full: byte dropped, then clear coinciding with a new overflow
      reset_counts(); rx_fifo_full = 1'b1;
      frame_start();
      send_bits(8'hE7, 8, 1'b0);
      frame_end();
      chk("ovf_no_wr", wrs, 0);
      chk("ovf_flag", rx_overflow, 1);
      frame_start();
      fork
         send_bits(8'h18, 8, 1'b0);
         begin
            n = 0;
            for (int c = 0; c < 400 && n < 8; c++) begin
               @(negedge pclk);
               if (slave_receive_shift_en) n++;
            end
            chk("ovf_wait_8_recv", n, 8);
            @(negedge pclk); clr_status = 1'b1;
            @(negedge pclk); clr_status = 1'b0;
            chk("ovf_set_wins", rx_overflow, 1);
         end
      join
      frame_end();
      chk("ovf_no_wr2", wrs, 0);
      pulse_clr();
      chk("ovf_cleared", rx_overflow, 0);
      rx_fifo_full = 1'b0;

      // abort after 5 bits, then a clean frame
      reset_counts();
      frame_start();
      send_bits(8'hFF, 5, 1'b0);
      frame_end();
      chk("abort_idle", state_dbg, 0);
      chk("abort_no_wr", wrs, 0);
      chk("abort_recvs", recvs, 5);
      exp_q.push_back(8'h6E);
      frame_start();
      send_bits(8'h6E, 8, 1'b0);
      frame_end();
      chk("abort_next_wr", wrs, 1);
      chk("abort_q_empty", exp_q.size(), 0);

      // reset mid-transfer in mode 0
      set_mode(1'b0, 1'b0);
      reset_counts(); tx_word = 8'h5A;
      frame_start();
      send_bits(8'hF0, 3, 1'b0);
      rst = 1'b1;
      #2;
      chk("mrst_state", state_dbg, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_strobes", {load_from_fifo, slave_transfer_shift_en, slave_receive_shift_en,
                           tx_fifo_rd, rx_fifo_wr}, 0);
      chk("mrst_flags", {tx_underflow, rx_overflow}, 0);
      repeat (3) @(negedge pclk);
      rst = 1'b0;
      repeat (4) @(negedge pclk);
      reset_counts();
      send_bits(8'hF0, 5, 1'b0);
      #(2*HALF);
      chk("mrst_no_strobes", loads + shifts + recvs + wrs, 0);
      chk("mrst_still_idle", state_dbg, 0);
      ss_pad_i = 1'b1;
      #(2*HALF);
      tx_word = 8'hC3; exp_q.push_back(8'h81);
      frame_start();
      send_bits(8'h81, 8, 1'b1);
      #(2*HALF);
      chk("mrst_new_frame_wr", wrs, 1);
      chk("mrst_new_frame_loads", loads, 1);
      chk("mrst_somi", somi_bits[7:0], 8'hC3);
      chk("mrst_q_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_sub_ctrl.md
SPI_SUB_CTRL -- requirements
Module: spi_sub_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per SPI character; SHALL match the slave shift register width.
REQ-002 Parameter SYNC_STAGES, default 2, flop count of each pad synchronizer; legal range 2..3.
REQ-003 pclk  in  1  system clock; the block has this one clock only, and all logic SHALL be clocked on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 sclk_pad_i  in  1  SPI serial clock from the master, asynchronous to pclk.
REQ-006 ss_pad_i  in  1  slave select, active-low, asynchronous to pclk.
REQ-007 cpol, cpha  in  1 each  SPI mode; quasi-static, changed only while ss_pad_i is high.
REQ-008 tx_fifo_empty  in  1  TX FIFO has no data.
REQ-009 rx_fifo_full  in  1  RX FIFO cannot accept data.
REQ-010 clr_status  in  1  one-cycle pulse that clears the sticky flags.
REQ-011 load_from_fifo  out  1  parallel-load strobe to the transmit shift register.
REQ-012 slave_transfer_shift_en  out  1  transmit shift strobe.
REQ-013 slave_receive_shift_en  out  1  receive shift strobe.
REQ-014 tx_fifo_rd  out  1  TX FIFO pop strobe.
REQ-015 rx_fifo_wr  out  1  RX FIFO push strobe; sub_rx is valid in this cycle.
REQ-016 busy  out  1  high in LOAD and XFER.
REQ-017 tx_underflow, rx_overflow  out  1 each  sticky error flags.

Function
REQ-018 sclk_pad_i and ss_pad_i SHALL each pass through a SYNC_STAGES synchronizer, then one further register for edge detection.
REQ-019 Leading edge SHALL be the rising sclk edge when cpol=0 and the falling edge when cpol=1; trailing edge is the opposite edge.
REQ-020 Sample edge SHALL be the leading edge when cpha=0 and the trailing edge when cpha=1; shift edge is the other edge.
REQ-021 FSM states SHALL be IDLE, LOAD and XFER; the reset state is IDLE.
REQ-022 IDLE -> LOAD SHALL occur on a synchronized ss falling edge.
REQ-023 LOAD SHALL last exactly one cycle, then transition to XFER.
REQ-024 XFER -> IDLE SHALL occur in the cycle the synchronized ss is seen high.
REQ-025 In LOAD, load_from_fifo SHALL be 1 for one cycle, bit_cnt SHALL be cleared and the fresh flag SHALL be set.
REQ-026 In XFER, each detected sample edge SHALL pulse slave_receive_shift_en for one cycle and increment bit_cnt, using a counter of width clog2(DATA_WIDTH)+1.
REQ-027 On the sample edge where bit_cnt reaches DATA_WIDTH, the block SHALL set byte_done and clear bit_cnt to 0.
REQ-028 rx_fifo_wr SHALL pulse one cycle after the final receive shift of a byte, when sub_rx holds the full byte, provided rx_fifo_full=0.
REQ-029 If rx_fifo_full=1 at that point, the byte SHALL be dropped, rx_fifo_wr SHALL stay low and rx_overflow SHALL be set.
REQ-030 In XFER, when a shift edge occurs and byte_done=1, the block SHALL pulse load_from_fifo instead of a shift, and SHALL clear byte_done.
REQ-031 In XFER, when a shift edge occurs with fresh=1 and cpha=1, the block SHALL take no action and SHALL clear fresh, because the first bit was already presented by LOAD.
REQ-032 In XFER, any other shift edge SHALL pulse slave_transfer_shift_en for one cycle.
REQ-033 With cpha=0, fresh SHALL clear on the first sample edge.
REQ-034 tx_fifo_rd SHALL accompany every load_from_fifo pulse when tx_fifo_empty=0.
REQ-035 When tx_fifo_empty=1 at a load, load_from_fifo SHALL still pulse, tx_fifo_rd SHALL stay low and tx_underflow SHALL be set.
REQ-036 load_from_fifo and slave_transfer_shift_en SHALL never be high in the same cycle.
REQ-037 The receive and transmit strobes SHALL never be high in the same cycle.
REQ-038 Deasserting ss mid-byte (bit_cnt != 0) SHALL abort the byte: no rx_fifo_wr, partial data discarded, bit_cnt and byte_done cleared.
REQ-039 An sclk edge detected in the same cycle as the ss deassertion SHALL be ignored.
REQ-040 Sclk edges detected while in IDLE or LOAD SHALL be ignored.
REQ-041 clr_status SHALL clear both sticky flags; if a set event occurs in the same cycle, set SHALL win.

Reset
REQ-042 While rst=1, the FSM SHALL be in IDLE, bit_cnt=0, byte_done=0 and fresh=0.
REQ-043 While rst=1, all strobes, busy and both flags SHALL be 0, and the synchronizers SHALL reset to idle levels (ss=1, sclk=cpol).
REQ-044 rst asserted mid-transfer SHALL force IDLE immediately.
REQ-045 After rst deasserts, the block SHALL wait for a fresh ss falling edge before starting a transfer.

Verification
REQ-046 Mode 0, ss low, 8 sclk cycles, master sends 0xA5 -> exactly one load, 7 transmit shifts, 8 receive shifts, rx_fifo_wr with sub_rx=0xA5, somi outputs the TX byte MSB first.
REQ-047 Mode 3, two back-to-back bytes 0x3C and 0xC3 -> the second load lands on the 9th leading edge; two rx_fifo_wr pulses in order 0x3C, 0xC3; no strobe overlap.
REQ-048 Mode 1, tx_fifo_empty=1 at ss fall -> load_from_fifo pulses, tx_fifo_rd stays 0, tx_underflow=1 until clr_status.
REQ-049 rx_fifo_full=1 at end of byte -> no rx_fifo_wr, rx_overflow=1; a clr_status pulse in the same cycle as a new overflow leaves rx_overflow=1.
REQ-050 ss raised after 5 bits -> IDLE, no rx_fifo_wr; the next frame receives a full correct byte.
REQ-051 rst pulsed after 3 bits -> all outputs 0 and state IDLE at once; sclk activity with ss still low produces no strobes until a new ss falling edge.
